// File: rtl/fetch_if.sv
// Fetch-side bus between the fetch sequencer, the program ROM and the decoder.
// The slave modport is the sequencer; the master modport is its environment.
interface fetch_if #(
  parameter int unsigned Psize = 5,
  parameter int unsigned Isize = 15
);
  logic             start;
  logic             stall;
  logic             branch_en;
  logic [Psize-1:0] branch_off;
  logic             jump_en;
  logic [Psize-1:0] jump_addr;
  logic             halt_req;
  logic [Isize-1:0] I_in;
  logic [Psize-1:0] address;
  logic [Isize-1:0] instr;
  logic [Psize-1:0] ir_pc;
  logic             instr_valid;
  logic             halted;
  logic             fault;
  logic [15:0]      retired;

  modport master (
    output start, stall, branch_en, branch_off, jump_en, jump_addr, halt_req, I_in,
    input  address, instr, ir_pc, instr_valid, halted, fault, retired
  );

  modport slave (
    input  start, stall, branch_en, branch_off, jump_en, jump_addr, halt_req, I_in,
    output address, instr, ir_pc, instr_valid, halted, fault, retired
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer for picoMIPS: drives the ROM address,
// captures instructions into IR and handles stall, branch, jump, halt and fault.
module fetch_ctrl #(
  parameter int unsigned Psize  = 5,
  parameter int unsigned Isize  = 15,
  parameter int unsigned Pdepth = 22
) (
  input  logic    clk,
  input  logic    resetn,
  fetch_if.slave  bus
);
  localparam int unsigned Tw = Psize + 1;
  localparam int unsigned Rw = 16;

  typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_t;

  state_t           state_q, state_d;
  logic [Psize-1:0] pc_q, pc_d;
  logic [Psize-1:0] irpc_q, irpc_d;
  logic [Isize-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [Rw-1:0]    ret_q, ret_d;

  logic [Tw-1:0]    br_tgt;
  logic [Tw-1:0]    tgt;
  logic             tgt_bad;
  logic [Psize-1:0] pc_seq;

  // One extra bit catches both negative and past-the-end targets in one compare.
  always_comb begin
    br_tgt  = {1'b0, irpc_q} + {bus.branch_off[Psize-1], bus.branch_off};
    tgt     = bus.jump_en ? {1'b0, bus.jump_addr} : br_tgt;
    tgt_bad = (tgt >= Tw'(Pdepth));
    pc_seq  = (pc_q == Psize'(Pdepth - 1)) ? '0 : pc_q + Psize'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q    <= '0;
      irpc_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      irpc_q  <= irpc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      ret_q   <= ret_d;
    end
  end

  // Next-state: control requests only act on a valid IR word; stall freezes everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    irpc_d  = irpc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    ret_d   = ret_q;
    case (state_q)
      RUN: begin
        if (!bus.stall) begin
          if (valid_q && (ret_q != '1)) ret_d = ret_q + Rw'(1);
          if (bus.halt_req && valid_q) begin
            state_d = HALTED;
            valid_d = 1'b0;
          end else if ((bus.jump_en || bus.branch_en) && valid_q) begin
            valid_d = 1'b0;
            if (tgt_bad) state_d = FAULT;
            else         pc_d    = tgt[Psize-1:0];
          end else begin
            instr_d = bus.I_in;
            irpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_seq;
          end
        end
      end
      default: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = '0;
          valid_d = 1'b0;
          ret_d   = '0;
        end
      end
    endcase
  end

  assign bus.address     = pc_q;
  assign bus.instr       = instr_q;
  assign bus.ir_pc       = irpc_q;
  assign bus.instr_valid = valid_q;
  assign bus.retired     = ret_q;
  assign bus.halted      = (state_q == HALTED);
  assign bus.fault       = (state_q == FAULT);
endmodule
